// File: rtl/module_display_scan_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment display driver.
// Glyph encodings are active-high {g,f,e,d,c,b,a}; the top level applies the polarity.
package pkg_display;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
  };

  localparam logic [6:0] SEG_OFF = '0;
  localparam logic [3:0] AN_OFF  = '0;

endpackage

// File: rtl/module_display_scan_if.sv
// Update handshake and display-drive signals between the datapath and the scan driver.
interface module_display_scan_if;
  logic [15:0] value_i;
  logic        upd_i;
  logic        lz_en_i;
  logic        upd_ack_o;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;

  modport master (
    output value_i, upd_i, lz_en_i,
    input  upd_ack_o, an_o, seg_o
  );

  modport slave (
    input  value_i, upd_i, lz_en_i,
    output upd_ack_o, an_o, seg_o
  );
endinterface

// File: rtl/module_display_scan_hex7seg.sv
// Combinational nibble to active-high 7-segment glyph lookup.
module module_hex7seg
  import pkg_display::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH[nibble];
  end

endmodule

// File: rtl/module_display_scan.sv
// Time-multiplexed 4-digit 7-segment scan driver with blanking gaps, frame-aligned
// value updates through a request/ack handshake, and optional leading-zero blanking.
module module_display_scan
  import pkg_display::*;
#(
  parameter int DIV_CYCLES   = 6750,
  parameter int BLANK_CYCLES = 270,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  module_display_scan_if.slave bus
);

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST       = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0] CNT_BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [3:0]    AN_IDLE        = ACTIVE_LOW ? ~AN_OFF : AN_OFF;
  localparam logic [6:0]    SEG_IDLE       = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      dig_q, dig_d;
  logic [15:0]     disp_q, disp_d;
  logic [15:0]     pend_q, pend_d;
  logic            pend_v_q, pend_v_d;
  logic            ack_q, ack_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            slot_end, boundary;
  logic [3:0]      nibble;
  logic [6:0]      glyph;
  logic            dark, lit;
  logic [3:0]      an_hi;
  logic [6:0]      seg_hi;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= BLANK;
      cnt_q    <= '0;
      dig_q    <= '0;
      disp_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      ack_q    <= 1'b0;
      an_q     <= AN_IDLE;
      seg_q    <= SEG_IDLE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      ack_q    <= ack_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    dig_d    = dig_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    ack_d    = 1'b0;
    slot_end = (cnt_q == CNT_LAST);
    boundary = slot_end && (dig_q == 2'd3);

    case (state_q)
      BLANK:   if (cnt_q == CNT_BLANK_LAST) state_d = SHOW;
      SHOW:    state_d = SHOW;
      default: state_d = BLANK;
    endcase

    if (slot_end) begin
      cnt_d   = '0;
      state_d = BLANK;
      dig_d   = dig_q + 2'd1;
    end

    // A request arriving in the boundary cycle itself bypasses the pending register.
    if (boundary) begin
      if (bus.upd_i) begin
        disp_d = bus.value_i;
        ack_d  = 1'b1;
      end else if (pend_v_q) begin
        disp_d = pend_q;
        ack_d  = 1'b1;
      end
      pend_v_d = 1'b0;
    end else if (bus.upd_i) begin
      pend_d   = bus.value_i;
      pend_v_d = 1'b1;
    end
  end

  module_hex7seg u_hex7seg (
    .nibble (nibble),
    .seg    (glyph)
  );

  // Outputs are encoded from the next-cycle scan state so the registered
  // anodes line up exactly with the state register.
  always_comb begin
    nibble = disp_d[4*dig_d +: 4];
    case (dig_d)
      2'd1:    dark = (disp_d[15:4]  == '0);
      2'd2:    dark = (disp_d[15:8]  == '0);
      2'd3:    dark = (disp_d[15:12] == '0);
      default: dark = 1'b0;
    endcase
    dark   = dark && bus.lz_en_i;
    lit    = (state_d == SHOW) && !dark;
    an_hi  = lit ? (4'b0001 << dig_d) : AN_OFF;
    seg_hi = lit ? glyph : SEG_OFF;
    an_d   = ACTIVE_LOW ? ~an_hi  : an_hi;
    seg_d  = ACTIVE_LOW ? ~seg_hi : seg_hi;
  end

  assign bus.upd_ack_o = ack_q;
  assign bus.an_o      = an_q;
  assign bus.seg_o     = seg_q;

endmodule

// File: tb/tb_module_display_scan.sv
// Self-checking bench for module_display_scan: directed scenarios plus random update
// traffic, compared cycle by cycle against a frame-arithmetic reference model.
module tb_module_display_scan;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  module_display_scan_if bus ();

  module_display_scan #(
    .DIV_CYCLES   (8),
    .BLANK_CYCLES (2),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: m counts clock edges since reset release.
  int          m;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  bit          m_pv;
  bit          m_ack;

  logic [6:0] ref_glyph [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  task automatic check_bits(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s at edge %0d observed %h expected %h", tag, m, obs, exp);
    end
  endtask

  task automatic model_reset();
    m      = 0;
    m_disp = '0;
    m_pend = '0;
    m_pv   = 1'b0;
    m_ack  = 1'b0;
  endtask

  task automatic model_edge(input logic u, input logic [15:0] v);
    m++;
    m_ack = 1'b0;
    if (m % 32 == 0) begin
      if (u) begin
        m_disp = v;
        m_ack  = 1'b1;
      end else if (m_pv) begin
        m_disp = m_pend;
        m_ack  = 1'b1;
      end
      m_pv = 1'b0;
    end else if (u) begin
      m_pend = v;
      m_pv   = 1'b1;
    end
  endtask

  task automatic step(input logic u, input logic [15:0] v, input logic lz);
    int          pos, dg;
    logic [15:0] hi;
    bit          lit;
    logic [3:0]  one_hot, exp_an;
    logic [6:0]  exp_seg;
    bus.upd_i   = u;
    bus.value_i = v;
    bus.lz_en_i = lz;
    @(posedge clk);
    model_edge(u, v);
    #1;
    pos     = m % 8;
    dg      = (m / 8) % 4;
    hi      = m_disp >> (4 * dg);
    lit     = (pos >= 2) && !(lz && dg != 0 && hi == 16'h0);
    one_hot = 4'b0001 << dg;
    exp_an  = lit ? ~one_hot : 4'hF;
    check_bits("an", {12'h0, bus.an_o}, {12'h0, exp_an});
    if (lit) begin
      exp_seg = ~ref_glyph[hi[3:0]];
      check_bits("seg_lit", {9'h0, bus.seg_o}, {9'h0, exp_seg});
    end else if (pos < 2) begin
      check_bits("seg_blank", {9'h0, bus.seg_o}, 16'h007F);
    end
    check_bits("ack", {15'h0, bus.upd_ack_o}, {15'h0, m_ack});
  endtask

  task automatic idle_until(input int target, input logic lz);
    while (m < target) step(1'b0, 16'h0, lz);
  endtask

  initial begin
    bit          lzr;
    logic [15:0] rv;
    bus.upd_i   = 1'b0;
    bus.value_i = '0;
    bus.lz_en_i = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_bits("rst_an",  {12'h0, bus.an_o},  16'h000F);
    check_bits("rst_seg", {9'h0, bus.seg_o},  16'h007F);
    check_bits("rst_ack", {15'h0, bus.upd_ack_o}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // First digit lights exactly after two edges
    step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    check_bits("first_lit_an", {12'h0, bus.an_o}, 16'h000E);

    // Mid-frame update, acked one cycle after the boundary
    idle_until(40, 1'b0);
    step(1'b1, 16'h1234, 1'b0);
    idle_until(64, 1'b0);
    check_bits("ack_1234", {15'h0, bus.upd_ack_o}, 16'h0001);
    idle_until(66, 1'b0);
    check_bits("digit4_seg", {9'h0, bus.seg_o}, {9'h0, 7'h19});

    // Last request in a frame wins, single ack
    idle_until(70, 1'b0);
    step(1'b1, 16'h0001, 1'b0);
    idle_until(80, 1'b0);
    step(1'b1, 16'h00AF, 1'b0);
    idle_until(128, 1'b0);

    // Bypass in the boundary cycle
    while ((m + 1) % 32 != 0) step(1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h5555, 1'b0);
    check_bits("bypass_ack", {15'h0, bus.upd_ack_o}, 16'h0001);
    idle_until(m + 32, 1'b0);

    // Leading-zero blanking
    step(1'b1, 16'h0070, 1'b1);
    idle_until(m + 64, 1'b1);
    step(1'b1, 16'h0000, 1'b1);
    idle_until(m + 64, 1'b1);

    // Random update traffic
    for (int f = 0; f < 16; f++) begin
      lzr = bit'($urandom_range(0, 1));
      for (int c = 0; c < 32; c++) begin
        rv = 16'($urandom);
        if ($urandom_range(0, 3) == 0) rv[15:8] = '0;
        step(($urandom_range(0, 15) == 0), rv, lzr);
      end
    end

    // Reset mid-SHOW with a pending request
    while (!((m % 8) == 4 && (m % 32) < 28)) step(1'b0, 16'h0, 1'b0);
    step(1'b1, 16'hABCD, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_bits("midrst_an",  {12'h0, bus.an_o},  16'h000F);
    check_bits("midrst_seg", {9'h0, bus.seg_o},  16'h007F);
    check_bits("midrst_ack", {15'h0, bus.upd_ack_o}, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle_until(80, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
